// File: rtl/gray_count_arbiter.sv
// gray_count_arbiter: round-robin burst arbiter that shares one Gray-code counter between two requesters.
module gray_count_arbiter #(
    parameter int WIDTH = 3,
    parameter int LEN_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             req0_i,
    input  logic [LEN_W-1:0] len0_i,
    input  logic             req1_i,
    input  logic [LEN_W-1:0] len1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] out_o,
    output logic             overflow_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] bin_q, bin_d, out_q;
    logic [LEN_W-1:0] rem_q, len_d;
    logic             last_q, pick1_d, accept_d;
    logic             gnt0_q, gnt1_q, busy_q, done_q, ovf_q;

    // On a tie, requester 1 wins only if requester 0 was granted last.
    always_comb begin
        accept_d = req0_i | req1_i;
        pick1_d  = req1_i & (~req0_i | ~last_q);
        len_d    = pick1_d ? len1_i : len0_i;
        bin_d    = bin_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bin_q   <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_i) begin
                        bin_q <= '0;
                        out_q <= '0;
                    end
                    if (accept_d) begin
                        gnt0_q <= ~pick1_d;
                        gnt1_q <= pick1_d;
                        busy_q <= 1'b1;
                        last_q <= pick1_d;
                        rem_q  <= len_d;
                        if (len_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    bin_q <= bin_d;
                    out_q <= bin_d ^ (bin_d >> 1);
                    ovf_q <= (bin_d == '0);
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0_o     = gnt0_q;
    assign gnt1_o     = gnt1_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign out_o      = out_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_gray_count_arbiter.sv
// tb_gray_count_arbiter: directed self-checking bench for gray_count_arbiter.
module tb_gray_count_arbiter;
    logic       clk, rst, clr, req0, req1;
    logic [3:0] len0, len1;
    logic       gnt0, gnt1, busy, done, ovf;
    logic [2:0] out;
    int         cmp = 0;
    int         errs = 0;

    gray_count_arbiter #(.WIDTH(3), .LEN_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .req0_i(req0), .len0_i(len0), .req1_i(req1), .len1_i(len1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .busy_o(busy), .done_o(done),
        .out_o(out), .overflow_o(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks every output against one expected vector.
    task automatic expect_all(input string tag, input logic g0, input logic g1, input logic b,
                              input logic d, input logic [2:0] o, input logic v);
        chk({tag, ".gnt0"}, 8'(gnt0), 8'(g0));
        chk({tag, ".gnt1"}, 8'(gnt1), 8'(g1));
        chk({tag, ".busy"}, 8'(busy), 8'(b));
        chk({tag, ".done"}, 8'(done), 8'(d));
        chk({tag, ".out"},  8'(out),  8'(o));
        chk({tag, ".ovf"},  8'(ovf),  8'(v));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        chk("excl", 8'(gnt0 & gnt1), 8'd0);
    endtask

    logic [2:0] walk [8];

    initial begin
        walk = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        rst = 0; clr = 0; req0 = 1; req1 = 1; len0 = 4'd3; len1 = 4'd2;
        #1 rst = 1;
        #1 expect_all("reset", 0, 0, 0, 0, 3'b000, 0);
        #18 rst = 0;
        // both request after release: requester 0 wins, Len0=3
        tick; expect_all("acc0", 1, 0, 1, 0, 3'b000, 0);
        req0 = 0; req1 = 0;
        tick; expect_all("run0a", 1, 0, 1, 0, 3'b001, 0);
        tick; expect_all("run0b", 1, 0, 1, 0, 3'b011, 0);
        tick; expect_all("done0", 1, 0, 1, 1, 3'b010, 0);
        tick; expect_all("idle0", 0, 0, 0, 0, 3'b010, 0);
        // contention, last granted was 0 so requester 1 goes first
        req0 = 1; req1 = 1; len0 = 4'd2; len1 = 4'd2;
        tick; expect_all("acc1", 0, 1, 1, 0, 3'b010, 0);
        tick; expect_all("run1a", 0, 1, 1, 0, 3'b110, 0);
        tick; expect_all("done1", 0, 1, 1, 1, 3'b111, 0);
        tick; expect_all("gap", 0, 0, 0, 0, 3'b111, 0);
        tick; expect_all("acc2", 1, 0, 1, 0, 3'b111, 0);
        tick; expect_all("run2a", 1, 0, 1, 0, 3'b101, 0);
        tick; expect_all("done2", 1, 0, 1, 1, 3'b100, 0);
        req0 = 0; req1 = 0;
        tick; expect_all("idle2", 0, 0, 0, 0, 3'b100, 0);
        // clear from all-ones count: no overflow
        clr = 1;
        tick; expect_all("clr", 0, 0, 0, 0, 3'b000, 0);
        clr = 0;
        // full wrap, Len1=8
        req1 = 1; len1 = 4'd8;
        tick; expect_all("acc8", 0, 1, 1, 0, 3'b000, 0);
        req1 = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            expect_all($sformatf("walk%0d", i), 0, 1, 1, logic'(i == 7), walk[i], logic'(i == 7));
        end
        tick; expect_all("idle8", 0, 0, 0, 0, 3'b000, 0);
        // zero-length burst
        req0 = 1; len0 = 4'd0;
        tick; expect_all("len0", 1, 0, 1, 1, 3'b000, 0);
        req0 = 0;
        tick; expect_all("len0idle", 0, 0, 0, 0, 3'b000, 0);
        // reset during second RUN cycle of Len=5
        req0 = 1; len0 = 4'd5;
        tick; expect_all("acc5", 1, 0, 1, 0, 3'b000, 0);
        req0 = 0;
        tick; expect_all("run5a", 1, 0, 1, 0, 3'b001, 0);
        #2 rst = 1;
        #1 expect_all("midrst", 0, 0, 0, 0, 3'b000, 0);
        #2 rst = 0;
        tick; expect_all("post1", 0, 0, 0, 0, 3'b000, 0);
        tick; expect_all("post2", 0, 0, 0, 0, 3'b000, 0);
        req1 = 1; len1 = 4'd1;
        tick; expect_all("accr", 0, 1, 1, 0, 3'b000, 0);
        req1 = 0;
        tick; expect_all("doner", 0, 1, 1, 1, 3'b001, 0);
        tick; expect_all("idler", 0, 0, 0, 0, 3'b001, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/gray_count_arbiter.md
Name: gray_count_arbiter

Overview:
- Shares one WIDTH-bit Gray-code counter between two requesters.
- Each requester asks for a burst of Len count steps. The block arbitrates round-robin, advances the counter exactly Len times, then signals completion.
- Sits between the P1 Gray counter datapath and the two agents that need sequenced Gray codes. It replaces the free-running En control of the plain counter.

Parameters:
- WIDTH, 3, counter width in bits (Output width).
- LEN_W, 4, width of the burst-length request fields.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Clr  input  1  synchronous counter clear; honoured only in IDLE.
- Req0  input  1  requester 0 burst request (level).
- Len0  input  LEN_W  requester 0 step count; sampled when its request is accepted.
- Req1  input  1  requester 1 burst request (level).
- Len1  input  LEN_W  requester 1 step count.
- Gnt0  output  1  requester 0 owns the counter.
- Gnt1  output  1  requester 1 owns the counter.
- Busy  output  1  a burst is in progress (state != IDLE).
- Done  output  1  one-cycle pulse: current burst finished.
- Output  output  WIDTH  current Gray code.
- Overflow  output  1  one-cycle pulse: counter wrapped to zero.

Behaviour:
- Reset (async, immediate):
  - Output=0, Gnt0=Gnt1=0, Busy=0, Done=0, Overflow=0.
  - State=IDLE, last-granted pointer=1, so requester 0 wins the first tie.
- Counter:
  - Internal binary count bin[WIDTH-1:0]; Output = bin ^ (bin>>1), driven from registers.
  - Each advance is bin+1 mod 2^WIDTH.
  - The count is not cleared between bursts. It is cleared only by Reset, or by Clr while in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Clr=1 -> bin=0 at the edge. Clr takes effect in the same edge as any request acceptance.
  - No Req -> stay in IDLE.
  - Only one Req high -> grant it.
  - Both Req high -> grant the requester other than the last-granted one. Update the last-granted pointer.
  - On acceptance, latch the granted Len into remaining.
  - Latched Len != 0 -> go to RUN; Len = 0 -> go directly to DONE.
  - Gnt and Busy rise in the cycle after acceptance.
- RUN:
  - Each cycle: bin advances once and remaining decrements.
  - When remaining==1 at the edge, perform the final advance and go to DONE.
  - Exactly Len advances occur; Len cycles are spent in RUN.
  - Req and Len changes are ignored during RUN.
- DONE:
  - Exactly one cycle: Done=1, Gnt still held, Busy=1, Output stable. Then go to IDLE.
- Grant latency and duration:
  - Request sampled at edge k -> Gnt high from cycle k+1 through cycle k+Len+1 inclusive (Len+1 cycles).
  - IDLE is re-entered at edge k+Len+2. Minimum of one IDLE cycle between bursts.
- Back-to-back requests:
  - A requester holding Req high after Done is treated as a new request.
  - Round-robin gives the other requester priority if it is also requesting.
- Overflow:
  - Registered with Output.
  - High for exactly the cycle in which Output first shows 0 as the result of an advance from bin = all-ones (Gray 100 for WIDTH=3).
  - Clr and Reset never assert Overflow.
  - Overflow may coincide with Done.
- Gnt0 and Gnt1 are never high simultaneously. Done implies Busy.
- Reset mid-burst:
  - Everything returns to reset values immediately.
  - No Done is produced for the aborted burst.

Test Plan:
- Reset asserted during the first 20 ns with Req0=Req1=1 -> Output=000, Gnt=00, Busy=0, Done=0, Overflow=0; the first grant after release goes to requester 0.
- Req0=1, Len0=3, from Output=000 -> Gnt0 high for 4 cycles; Output=001, 011, 010 on successive RUN edges; Done pulses once with Output=010; then IDLE.
- Req0=Req1=1, Len0=Len1=2, held until each Done -> requester 0 is served first (Output 001, 011), one IDLE cycle, then requester 1 (Output 010, 110); Gnt0 and Gnt1 never overlap.
- Req1=1, Len1=8, from Output=000 -> Output walks 001, 011, 010, 110, 111, 101, 100, 000; Overflow=1 only in the cycle showing the final 000, coincident with Done.
- Len0=0 -> Gnt0 and Done high for a single cycle; Output unchanged; Overflow=0. Separately, Clr in IDLE with Output=110 -> Output=000 next cycle, no Overflow.
- Reset asserted on the 2nd RUN cycle of a Len=5 burst -> outputs clear within the same cycle (asynchronous); no Done pulse; the next burst starts from Output=000.
